// File: rtl/ac_peak_detector.sv
// Windowed peak/trough capture of the P3 bandpass ADC stream, with peak-to-peak and rail-clip reporting.
// Optional build macro PEAK_DC_OFFSET_EN adds the (max+min)/2 midpoint on m_dc; otherwise m_dc is tied to 0.
//
//   state  | meaning
//   -------+--------------------------------------------------------------
//   IDLE   | waiting for start; samples accepted and discarded
//   ACQ    | accumulating running max/min/clip over 2^WIN_LOG2 samples
//   REPORT | result presented on m_*; sample port stalled until m_ready

module ac_peak_detector #(
    parameter int DW       = 16,
    parameter int WIN_LOG2 = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_max,
    output logic [DW-1:0] m_min,
    output logic [DW:0]   m_pp,
    output logic [DW-1:0] m_dc,
    output logic          m_ovf,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACQ    = 2'd1,
        REPORT = 2'd2
    } state_t;

    localparam logic signed [DW-1:0] POS_RAIL = {1'b0, {(DW-1){1'b1}}};
    localparam logic signed [DW-1:0] NEG_RAIL = {1'b1, {(DW-1){1'b0}}};
    localparam logic [WIN_LOG2:0]    WIN_LEN  = {1'b1, {WIN_LOG2{1'b0}}};
    localparam logic [WIN_LOG2:0]    CNT_ONE  = {{WIN_LOG2{1'b0}}, 1'b1};

    state_t                  state_q,   state_d;
    logic [WIN_LOG2:0]       count_q,   count_d;
    logic signed [DW-1:0]    run_max_q, run_max_d;
    logic signed [DW-1:0]    run_min_q, run_min_d;
    logic                    run_ovf_q, run_ovf_d;
    logic signed [DW-1:0]    m_max_q,   m_max_d;
    logic signed [DW-1:0]    m_min_q,   m_min_d;
    logic [DW:0]             m_pp_q,    m_pp_d;
    logic signed [DW-1:0]    m_dc_q,    m_dc_d;
    logic                    m_ovf_q,   m_ovf_d;

    logic signed [DW-1:0]    sample;
    logic signed [DW-1:0]    next_max;
    logic signed [DW-1:0]    next_min;
    logic                    next_ovf;
    logic [WIN_LOG2:0]       count_inc;
    logic [DW:0]             pp_calc;
    logic signed [DW-1:0]    dc_calc;

    // Candidate running values assuming the current sample is accepted.
    assign sample    = $signed(s_data);
    assign next_max  = (sample > run_max_q) ? sample : run_max_q;
    assign next_min  = (sample < run_min_q) ? sample : run_min_q;
    assign next_ovf  = run_ovf_q | (sample == POS_RAIL) | (sample == NEG_RAIL);
    assign count_inc = count_q + CNT_ONE;
    assign pp_calc   = {next_max[DW-1], next_max} - {next_min[DW-1], next_min};

`ifdef PEAK_DC_OFFSET_EN
    logic [DW:0] dc_sum;
    assign dc_sum  = {next_max[DW-1], next_max} + {next_min[DW-1], next_min};
    assign dc_calc = $signed(dc_sum[DW:1]);
`else
    assign dc_calc = '0;
`endif

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        run_max_d = run_max_q;
        run_min_d = run_min_q;
        run_ovf_d = run_ovf_q;
        m_max_d   = m_max_q;
        m_min_d   = m_min_q;
        m_pp_d    = m_pp_q;
        m_dc_d    = m_dc_q;
        m_ovf_d   = m_ovf_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = ACQ;
                    count_d   = '0;
                    run_max_d = NEG_RAIL;
                    run_min_d = POS_RAIL;
                    run_ovf_d = 1'b0;
                end
            end
            ACQ: begin
                if (s_valid) begin
                    run_max_d = next_max;
                    run_min_d = next_min;
                    run_ovf_d = next_ovf;
                    count_d   = count_inc;
                    if (count_inc == WIN_LEN) begin
                        m_max_d = next_max;
                        m_min_d = next_min;
                        m_pp_d  = pp_calc;
                        m_dc_d  = dc_calc;
                        m_ovf_d = next_ovf;
                        state_d = REPORT;
                    end
                end
            end
            REPORT: begin
                if (m_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            count_q   <= '0;
            run_max_q <= '0;
            run_min_q <= '0;
            run_ovf_q <= 1'b0;
            m_max_q   <= '0;
            m_min_q   <= '0;
            m_pp_q    <= '0;
            m_dc_q    <= '0;
            m_ovf_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            run_max_q <= run_max_d;
            run_min_q <= run_min_d;
            run_ovf_q <= run_ovf_d;
            m_max_q   <= m_max_d;
            m_min_q   <= m_min_d;
            m_pp_q    <= m_pp_d;
            m_dc_q    <= m_dc_d;
            m_ovf_q   <= m_ovf_d;
        end
    end

    assign s_ready = (state_q != REPORT);
    assign m_valid = (state_q == REPORT);
    assign busy    = (state_q == ACQ);
    assign m_max   = m_max_q;
    assign m_min   = m_min_q;
    assign m_pp    = m_pp_q;
    assign m_dc    = m_dc_q;
    assign m_ovf   = m_ovf_q;

endmodule
